// File: rtl/gate_array_pipe_pkg.sv
// gate_array_pipe_pkg: shared gate-mode encoding for the pipelined gate array.
//   Package gate_pkg
//     mode_t   : 3-bit gate select, MODE_AND .. MODE_RSVD
//     MODE_CNT : number of encodable modes
package gate_pkg;

    typedef enum logic [2:0] {
        MODE_AND,
        MODE_OR,
        MODE_NAND,
        MODE_NOR,
        MODE_XOR,
        MODE_XNOR,
        MODE_NOT,
        MODE_RSVD
    } mode_t;

    localparam int MODE_CNT = 8;

endpackage

// File: rtl/gate_array_pipe_if.sv
// gate_array_pipe_if: valid/ready bundle for the gate array stage.
//   Input side : in_valid, in_ready, mode[2:0], operands[NUM_IN*WIDTH-1:0]
//   Output side: out_valid, out_ready, result[WIDTH-1:0], out_err
//   master     : environment (drives operands and out_ready)
//   slave      : the gate array block
interface gate_array_pipe_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 2
);

    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              mode;
    logic [NUM_IN*WIDTH-1:0] operands;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        result;
    logic                    out_err;

    modport master (
        output in_valid, mode, operands, out_ready,
        input  in_ready, out_valid, result, out_err
    );

    modport slave (
        input  in_valid, mode, operands, out_ready,
        output in_ready, out_valid, result, out_err
    );

endinterface

// File: rtl/gate_reduce.sv
// gate_reduce: combinational bitwise reduction of NUM_IN operands by gate mode.
//   mode     in  gate select (mode_t)
//   operands in  NUM_IN*WIDTH, operand i at [i*WIDTH +: WIDTH]
//   result   out WIDTH, gate output (zero for reserved mode)
//   err      out high for reserved mode
module gate_reduce
    import gate_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 2
) (
    input  mode_t                   mode,
    input  logic [NUM_IN*WIDTH-1:0] operands,
    output logic [WIDTH-1:0]        result,
    output logic                    err
);

    logic [WIDTH-1:0] and_r, or_r, xor_r;

    // Full-width reductions first; inverted modes invert the whole reduction.
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            and_r = and_r & operands[i*WIDTH +: WIDTH];
            or_r  = or_r  | operands[i*WIDTH +: WIDTH];
            xor_r = xor_r ^ operands[i*WIDTH +: WIDTH];
        end
    end

    assign result = (mode == MODE_AND)  ? and_r  :
                    (mode == MODE_OR)   ? or_r   :
                    (mode == MODE_NAND) ? ~and_r :
                    (mode == MODE_NOR)  ? ~or_r  :
                    (mode == MODE_XOR)  ? xor_r  :
                    (mode == MODE_XNOR) ? ~xor_r :
                    (mode == MODE_NOT)  ? ~operands[WIDTH-1:0] : '0;
    assign err = (mode == MODE_RSVD);

endmodule

// File: rtl/gate_array_pipe.sv
// gate_array_pipe: two-stage back-pressurable bitwise gate array with result counter.
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   bus      slave side of gate_array_pipe_if (valid/ready in, valid/ready out)
//   op_count out CNT_W, completed output handshakes, wrapping
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_array_pipe_if.slave bus,
    output logic [CNT_W-1:0] op_count
);

    logic                    s1_v, s2_v, adv1, adv2, f_err;
    mode_t                   s1_mode;
    logic [NUM_IN*WIDTH-1:0] s1_ops;
    logic [WIDTH-1:0]        f_res;

    // A stage may load when it is empty or its contents move on this edge.
    assign adv2          = !s2_v || bus.out_ready;
    assign adv1          = !s1_v || adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_v;

    // Stage-1 data is qualified by s1_v, so it needs no reset.
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            s1_mode <= mode_t'(bus.mode);
            s1_ops  <= bus.operands;
        end
    end

    gate_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .mode     (s1_mode),
        .operands (s1_ops),
        .result   (f_res),
        .err      (f_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            bus.result  <= '0;
            bus.out_err <= 1'b0;
            op_count    <= '0;
        end else begin
            if (adv1)
                s1_v <= bus.in_valid;
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    bus.result  <= f_res;
                    bus.out_err <= f_err;
                end
            end
            if (s2_v && bus.out_ready)
                op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
